reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 161 ++++++++++++++++
 tb/tb_reg_dump.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reg_dump
//
// Walks a register bank through its combinational read port and streams the
// registers selected by a mask out over a valid/ready interface. Each selected
// register is snapshotted into an output holding register, so later bank
// writes cannot disturb a word that is waiting for the consumer.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   start      begin a dump (honoured only when idle)
//   abort      terminate the dump in progress
//   mask       registers to dump, one bit per register, sampled at start
//   rd_addr    read address to the register bank
//   rd_data    combinational read data from the register bank
//   out_valid  out_addr/out_data/out_last valid
//   out_ready  consumer accepts the current word
//   out_addr   register index of the current word
//   out_data   snapshot of the register value
//   out_last   final word of this dump
//   busy       high whenever a dump is in progress (state != IDLE)
//   done       one-cycle pulse on normal completion
//   count      words accepted since the last start
// -----------------------------------------------------------------------------
module reg_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2**ADDR_W-1:0]   mask,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W:0]        count
);

  localparam int NREGS = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NREGS-1:0]    r_mask_q;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_out_valid;
  logic                r_out_last;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [DATA_W-1:0]   r_out_data;

  logic [NREGS-1:0]    w_above;     // bit i set when register i lies above ptr
  logic                w_sel;       // current register is selected
  logic                w_is_last;   // no selected register remains above ptr

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_above[i] = (i > int'(r_ptr));
    end
  end

  assign w_sel     = r_mask_q[r_ptr];
  assign w_is_last = ~|(r_mask_q & w_above);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // abort beats start in IDLE and beats the handshake in SEND.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start && !abort) w_state_next = (|mask) ? SCAN : DONE;
      SCAN: begin
        if (abort)      w_state_next = IDLE;
        else if (w_sel) w_state_next = SEND;
      end
      SEND: begin
        if (abort)          w_state_next = IDLE;
        else if (out_ready) w_state_next = r_out_last ? DONE : SCAN;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the output data holding register is reset along with the control
  // state, so every output has a defined value the moment rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_q    <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_count <= '0;
            if (|mask) begin
              r_mask_q <= mask;
              r_ptr    <= '0;
            end
          end
        end
        SCAN: begin
          if (!abort) begin
            if (w_sel) begin
              r_out_data  <= rd_data;
              r_out_addr  <= r_ptr;
              r_out_valid <= 1'b1;
              r_out_last  <= w_is_last;
            end else begin
              // A later selected bit always exists here, so ptr never wraps.
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        SEND: begin
          if (abort) begin
            r_out_valid <= 1'b0;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_count     <= r_count + 1'b1;
            if (!r_out_last) r_ptr <= r_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr   = r_ptr;
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign count     = r_count;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_reg_dump.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reg_dump
//
// Directed bench for reg_dump: a table of complete dumps with out_ready held
// high (word sequence, last flag, final count and start-to-done cycle count),
// plus hand-written sequences for back-pressure, abort and mid-dump reset.
// -----------------------------------------------------------------------------
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] mask;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  logic [31:0] bank [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rd_data = bank[rd_addr];

  reg_dump #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mask      (mask),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  typedef struct {
    logic [15:0] mask;
    logic [31:0] r3;
    int          exp_words;
    int          exp_cycles;
    int          exp_first_addr;
    logic [31:0] exp_first_data;
    int          exp_last_addr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int next_set(input logic [15:0] m, input int from);
    for (int i = from; i < 16; i++) begin
      if (m[i]) return i;
    end
    return 16;
  endfunction

  task automatic fill_bank(input logic [31:0] r3);
    for (int i = 0; i < 16; i++) bank[i] = 32'(i);
    bank[3] = r3;
  endtask

  // Runs one dump with out_ready high and checks it against a table entry.
  task automatic do_dump(input vec_t v);
    int          cyc;
    int          words;
    int          prev;
    int          exp_a;
    logic [31:0] exp_d;
    fill_bank(v.r3);
    out_ready = 1'b1;
    @(negedge clk);
    mask  = v.mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    words = 0;
    prev  = -1;
    while (!done && cyc < 100) begin
      if (out_valid) begin
        exp_a = next_set(v.mask, prev + 1);
        exp_d = (exp_a == 3) ? v.r3 : 32'(exp_a);
        check("word_addr_data_last", {out_addr, out_data, out_last},
              {4'(exp_a), exp_d, (words == v.exp_words - 1)});
        if (words == 0) begin
          check("first_addr", 64'(out_addr), 64'(v.exp_first_addr));
          check("first_data", 64'(out_data), 64'(v.exp_first_data));
        end
        if (words == v.exp_words - 1)
          check("last_addr", 64'(out_addr), 64'(v.exp_last_addr));
        prev = exp_a;
        words++;
      end
      if (out_valid === 1'b1 || busy === 1'b1) ; else
        check("busy_during_dump", 64'(busy), 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check("start_to_done_cycles", 64'(cyc), 64'(v.exp_cycles));
    check("words_seen", 64'(words), 64'(v.exp_words));
    check("final_count", 64'(count), 64'(v.exp_words));
    @(posedge clk); #1;
    check("after_done_idle", {busy, done, out_valid}, 3'b000);
  endtask

  initial begin : main
    int          words;
    int          guard;
    logic        saw_done;
    logic [31:0] held;

    vecs[0] = '{16'h0008, 32'hDEADBEEF,  1,  6,  3, 32'hDEADBEEF,  3};
    vecs[1] = '{16'hFFFF, 32'h00000003, 16, 33,  0, 32'h00000000, 15};
    vecs[2] = '{16'h0005, 32'h00000003,  2,  6,  0, 32'h00000000,  2};
    vecs[3] = '{16'h8000, 32'h00000003,  1, 18, 15, 32'h0000000F, 15};
    vecs[4] = '{16'h0001, 32'h00000003,  1,  3,  0, 32'h00000000,  0};
    vecs[5] = '{16'h8001, 32'h00000003,  2, 19,  0, 32'h00000000, 15};
    vecs[6] = '{16'h00A0, 32'h00000003,  2, 11,  5, 32'h00000005,  7};
    vecs[7] = '{16'h0000, 32'h00000003,  0,  1,  0, 32'h00000000,  0};

    fill_bank(32'h3);
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    mask      = 16'h0;
    out_ready = 1'b1;

    // Reset values are visible before any clock edge.
    #3;
    check("reset_outputs",
          {busy, done, out_valid, out_last, rd_addr, count, out_addr, out_data},
          '0);
    @(negedge clk);
    rst = 1'b0;

    // Table of complete dumps.
    for (int i = 0; i < 8; i++) do_dump(vecs[i]);

    // Back-pressure: word 0 held for 5 stalled cycles while r0 is rewritten.
    fill_bank(32'h3);
    bank[0]   = 32'h1234_5678;
    out_ready = 1'b0;
    @(negedge clk);
    mask  = 16'h0005;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("stall_first_word", {out_valid, out_addr, out_data, out_last},
          {1'b1, 4'd0, 32'h1234_5678, 1'b0});
    held    = out_data;
    bank[0] = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_hold", {out_valid, out_addr, out_data}, {1'b1, 4'd0, held});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_accepted", {out_valid, count}, {1'b0, 5'd1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_second_word", {out_valid, out_addr, out_data, out_last},
          {1'b1, 4'd2, 32'h2, 1'b1});
    @(posedge clk); #1;
    check("stall_done", {done, count}, {1'b1, 5'd2});
    @(posedge clk); #1;

    // Abort in the 4th SEND with out_ready high; a start mid-dump is ignored.
    fill_bank(32'h3);
    out_ready = 1'b1;
    @(negedge clk);
    mask  = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    words = 0;
    guard = 0;
    while (guard < 40) begin
      if (out_valid) begin
        check("abort_run_addr", 64'(out_addr), 64'(words));
        words++;
        if (words == 2) begin
          start = 1'b1;
          mask  = 16'h0001;
        end
        if (words == 3) start = 1'b0;
        if (words == 4) begin
          abort = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    check("abort_reached_4th_send", 64'(words), 64'd4);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", {busy, out_valid, done, count}, {3'b000, 5'd3});
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {saw_done, busy, count}, {2'b00, 5'd3});

    // abort and start together in IDLE: abort wins.
    @(negedge clk);
    mask  = 16'hFFFF;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", {busy, done, count}, {2'b00, 5'd3});

    // Asynchronous reset in the middle of a SCAN.
    @(negedge clk);
    mask  = 16'h8000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scan_ptr_before_reset", {busy, rd_addr}, {1'b1, 4'd4});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {busy, done, out_valid, out_last, rd_addr, count, out_addr, out_data},
          '0);
    @(negedge clk);
    rst = 1'b0;
    do_dump(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
